// File: rtl/count_arbiter.sv
// count_arbiter: two requesters share one up-counter. The winner's terminal
// count is latched at grant, the counter runs from 0 to that value, and a
// one-cycle done pulse is issued to the owner before returning to idle.
// Dropping the owner's request mid-run abandons the run without a done pulse.
//
// Build option:
//   COUNT_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                            undefined -> round-robin between requesters
module count_arbiter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] target0,
    input  logic [CNT_W-1:0] target1,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             cnt_enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [1:0]       r_grant;
    logic [1:0]       r_done;
    logic             r_busy;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_tgtQ;

    // Index of the requester chosen this cycle (0 or 1); only meaningful
    // while the FSM is idle and at least one request is present.
    logic             w_winner;
    // The current owner still wants the counter.
    logic             w_ownerReq;
    // The counter has reached the latched terminal count.
    logic             w_match;

`ifdef COUNT_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking; requester 1 only when alone.
    assign w_winner = ~req[0];
`else
    // Remembers which requester was granted most recently, so that under
    // contention the other one goes next. Starts at 1 so requester 0 wins
    // the first contention after reset.
    logic r_lastServed;

    // Record the winner on every grant taken out of IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastServed <= 1'b1;
        end else if (r_state == IDLE && req != 2'b00) begin
            r_lastServed <= w_winner;
        end
    end

    assign w_winner = (req == 2'b11) ? ~r_lastServed : ~req[0];
`endif

    assign w_ownerReq = |(req & r_grant);
    assign w_match    = (r_count == r_tgtQ);

    // Main control FSM: arbitration, counting, completion and abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_count <= CNT_ZERO;
            r_tgtQ  <= CNT_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 2'b00;
                    r_count <= CNT_ZERO;
                    if (req != 2'b00) begin
                        r_state <= COUNT;
                        r_grant <= w_winner ? 2'b10 : 2'b01;
                        r_tgtQ  <= w_winner ? target1 : target0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_grant <= 2'b00;
                        r_busy  <= 1'b0;
                    end
                end
                COUNT: begin
                    if (!w_ownerReq) begin
                        // Owner walked away: abandon quietly.
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                        r_count <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end else if (w_match) begin
                        r_state <= DONE;
                        r_done  <= r_grant;
                        r_grant <= 2'b00;
                        r_count <= CNT_ZERO;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 2'b00;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                    r_done  <= 2'b00;
                    r_busy  <= 1'b0;
                    r_count <= CNT_ZERO;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign done       = r_done;
    assign busy       = r_busy;
    assign count      = r_count;
    assign cnt_enable = (r_state == COUNT) && w_ownerReq && !w_match;

    // Ownership is exclusive and never overlaps a completion pulse.
    grant_onehot0 : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(r_grant));
    done_not_with_grant : assert property (@(posedge clk) disable iff (!reset)
        !((|r_done) && (|r_grant)));

endmodule

// File: tb/tb_count_arbiter.sv
// tb_count_arbiter: directed scenarios with a grant/done scoreboard.
// The stimulus process queues the expected grant and done values for every
// run it starts; a monitor pops and compares them when the DUT shows a new
// grant or a done pulse. Cycle-level checks of count/busy/cnt_enable are made
// directly by the stimulus process.
module tb_count_arbiter;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [CNT_W-1:0] target0;
    logic [CNT_W-1:0] target1;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic             busy;
    logic [CNT_W-1:0] count;
    logic             cnt_enable;

    int errors = 0;
    int checks = 0;

    logic [1:0] grantQ[$];
    logic [1:0] doneQ[$];
    logic [1:0] prevGrant = 2'b00;

    count_arbiter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .target0   (target0),
        .target1   (target1),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count     (count),
        .cnt_enable(cnt_enable)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: compares every new grant and every done pulse
    // against the front of the matching expectation queue.
    always @(negedge clk) begin
        logic [1:0] exp;
        if (grant != 2'b00 && prevGrant == 2'b00) begin
            checks++;
            if (grantQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_grant: got grant=%b, none expected", grant);
            end else begin
                exp = grantQ.pop_front();
                if (grant !== exp) begin
                    errors++;
                    $display("[TB] FAIL sb_grant: got grant=%b, expected %b", grant, exp);
                end
            end
        end
        if (done != 2'b00) begin
            checks++;
            if (doneQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_done: got done=%b, none expected", done);
            end else begin
                exp = doneQ.pop_front();
                if (done !== exp) begin
                    errors++;
                    $display("[TB] FAIL sb_done: got done=%b, expected %b", done, exp);
                end
            end
        end
        prevGrant = grant;
    end

    // Hard stop in case something hangs.
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [CNT_W-1:0] t0,
                                 input logic [CNT_W-1:0] t1);
        req     = r;
        target0 = t0;
        target1 = t1;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] eGrant,
                               input logic [1:0] eDone, input logic eBusy,
                               input logic [CNT_W-1:0] eCount, input logic eEn);
        checks++;
        if ({grant, done, busy, count, cnt_enable} !== {eGrant, eDone, eBusy, eCount, eEn}) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%b done=%b busy=%b count=%0d en=%b, expected grant=%b done=%b busy=%b count=%0d en=%b",
                     name, grant, done, busy, count, cnt_enable,
                     eGrant, eDone, eBusy, eCount, eEn);
        end
    endtask

    task automatic doReset(input string name);
        reset = 1'b0;
        applyStimulus(2'b00, '0, '0);
        tick();
        tick();
        checkOutput(name, 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        int doneSeen;
        reset = 1'b0;
        applyStimulus(2'b00, '0, '0);

        // Basic run: requester 0, target 3.
        doReset("reset_state");
        grantQ.push_back(2'b01);
        doneQ.push_back(2'b01);
        applyStimulus(2'b01, 4'd3, 4'd0);
        tick();
        checkOutput("basic_e1", 2'b01, 2'b00, 1'b1, 4'd0, 1'b1);
        tick();
        checkOutput("basic_e2", 2'b01, 2'b00, 1'b1, 4'd1, 1'b1);
        tick();
        checkOutput("basic_e3", 2'b01, 2'b00, 1'b1, 4'd2, 1'b1);
        tick();
        checkOutput("basic_e4", 2'b01, 2'b00, 1'b1, 4'd3, 1'b0);
        tick();
        checkOutput("basic_e5_done", 2'b00, 2'b01, 1'b1, 4'd0, 1'b0);
        req = 2'b00;
        tick();
        checkOutput("basic_e6_idle", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);

        // Contention: both requesting, targets 2 and 1.
        doReset("reset_before_contention");
`ifdef COUNT_ARB_FIXED_PRIO_EN
        grantQ.push_back(2'b01); grantQ.push_back(2'b01); grantQ.push_back(2'b01);
        doneQ.push_back(2'b01);  doneQ.push_back(2'b01);  doneQ.push_back(2'b01);
`else
        grantQ.push_back(2'b01); grantQ.push_back(2'b10); grantQ.push_back(2'b01);
        doneQ.push_back(2'b01);  doneQ.push_back(2'b10);  doneQ.push_back(2'b01);
`endif
        applyStimulus(2'b11, 4'd2, 4'd1);
        tick();
        checkOutput("contend_first", 2'b01, 2'b00, 1'b1, 4'd0, 1'b1);
        doneSeen = 0;
        for (int i = 0; i < 40 && doneSeen < 3; i++) begin
            tick();
            if (done != 2'b00) doneSeen++;
        end
        req = 2'b00;
        checks++;
        if (doneSeen != 3) begin
            errors++;
            $display("[TB] FAIL contend_timeout: got %0d done pulses, expected 3", doneSeen);
        end
        tick();
        checkOutput("contend_idle", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);

        // Zero target on requester 1.
        grantQ.push_back(2'b10);
        doneQ.push_back(2'b10);
        applyStimulus(2'b10, 4'd9, 4'd0);
        tick();
        checkOutput("zero_tgt_grant", 2'b10, 2'b00, 1'b1, 4'd0, 1'b0);
        tick();
        checkOutput("zero_tgt_done", 2'b00, 2'b10, 1'b1, 4'd0, 1'b0);
        req = 2'b00;
        tick();
        checkOutput("zero_tgt_idle", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);

        // Abort at count 2 of target 5; target change while granted is ignored.
        grantQ.push_back(2'b01);
        applyStimulus(2'b01, 4'd5, 4'd0);
        tick();
        checkOutput("abort_grant", 2'b01, 2'b00, 1'b1, 4'd0, 1'b1);
        target0 = 4'd1;
        tick();
        tick();
        checkOutput("abort_cnt2", 2'b01, 2'b00, 1'b1, 4'd2, 1'b1);
        req = 2'b00;
        tick();
        checkOutput("abort_idle", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        tick();
        checkOutput("abort_no_done", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);

        // Reset mid-run at count 7 of target 15, then resume service.
        grantQ.push_back(2'b01);
        applyStimulus(2'b01, 4'd15, 4'd0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("midreset_cnt7", 2'b01, 2'b00, 1'b1, 4'd7, 1'b1);
        reset = 1'b0;
        #1;
        checkOutput("midreset_immediate", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        req = 2'b00;
        tick();
        checkOutput("midreset_held", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);
        reset = 1'b1;
        grantQ.push_back(2'b10);
        doneQ.push_back(2'b10);
        applyStimulus(2'b10, 4'd0, 4'd2);
        tick();
        checkOutput("resume_grant", 2'b10, 2'b00, 1'b1, 4'd0, 1'b1);
        tick();
        tick();
        checkOutput("resume_cnt2", 2'b10, 2'b00, 1'b1, 4'd2, 1'b0);
        tick();
        checkOutput("resume_done", 2'b00, 2'b10, 1'b1, 4'd0, 1'b0);
        req = 2'b00;
        tick();
        checkOutput("resume_idle", 2'b00, 2'b00, 1'b0, 4'd0, 1'b0);

        // Every queued expectation must have been consumed.
        tick();
        tick();
        checks++;
        if (grantQ.size() != 0 || doneQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_drain: got %0d grants and %0d dones pending, expected 0 and 0",
                     grantQ.size(), doneQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
